// File: rtl/output_port_allocator.sv
// -----------------------------------------------------------------------------
// output_port_allocator
//
// Switch allocator for the seven-port (E, W, N, S, PE, UP, DOWN) wormhole
// router. Each output port runs its own IDLE/LOCKED FSM with round-robin
// arbitration over the inputs that request it. The winning input keeps the
// output until its tail flit has crossed the crossbar.
//
// Port index everywhere: 0=E, 1=W, 2=N, 3=S, 4=PE, 5=UP, 6=DOWN.
//
// Ports
//   clk        in   1     rising-edge clock
//   rst        in   1     asynchronous active-low reset
//   req_valid  in   NP    input i has a routed flit at its FIFO head
//   req_port   in   3*NP  [3i+2:3i] destination output of input i (7 = none)
//   flit_tail  in   NP    head flit of input i is a tail flit
//   out_ready  in   NP    downstream of output o can accept a flit
//   rd_en      out  NP    pop input FIFO i this cycle
//   out_en     out  NP    crossbar output o carries a valid flit this cycle
//   out_sel    out  3*NP  [3o+2:3o] input index owning output o
//   out_busy   out  NP    output o is locked to a packet
// -----------------------------------------------------------------------------
module output_port_allocator #(
  parameter int NP = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NP-1:0]     req_valid,
  input  logic [3*NP-1:0]   req_port,
  input  logic [NP-1:0]     flit_tail,
  input  logic [NP-1:0]     out_ready,
  output logic [NP-1:0]     rd_en,
  output logic [NP-1:0]     out_en,
  output logic [3*NP-1:0]   out_sel,
  output logic [NP-1:0]     out_busy
);

  localparam int IW = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Per-output registered state.
  state_e          state_q [NP];
  logic [IW-1:0]   owner_q [NP];
  logic [IW-1:0]   ptr_q   [NP];
  logic [NP-1:0]   busy_q;

  // Combinational arbitration / transfer signals.
  logic [NP-1:0]   held;            // input i currently owns some locked output
  logic [NP-1:0]   cand    [NP];    // cand[o][i]: input i is eligible for output o
  logic [NP-1:0]   win_vld;
  logic [IW-1:0]   win_idx [NP];
  logic [NP-1:0]   xfer;            // locked output o moves a flit this cycle
  logic [NP-1:0]   owner_tail;      // flit being moved on output o is a tail

  // Candidate qualification. An input that already holds a lock is excluded,
  // which is what guarantees an input can never own two outputs at once.
  always_comb begin
    held = '0;
    for (int o = 0; o < NP; o++) begin
      if (state_q[o] == LOCKED) held[owner_q[o]] = 1'b1;
    end
    for (int o = 0; o < NP; o++) begin
      cand[o] = '0;
      for (int i = 0; i < NP; i++) begin
        cand[o][i] = req_valid[i]
                   && (req_port[IW*i +: IW] == IW'(o))
                   && (i != o)
                   && !held[i];
      end
    end
  end

  // Round-robin search starting one past the last owner, wrapping NP-1 -> 0.
  // The pointer only ever holds 0..NP-1, so one subtraction wraps it.
  always_comb begin
    int            c;
    logic [IW-1:0] idx;
    c   = 0;
    idx = '0;
    for (int o = 0; o < NP; o++) begin
      win_vld[o] = 1'b0;
      win_idx[o] = '0;
      for (int k = 1; k <= NP; k++) begin
        c = int'(ptr_q[o]) + k;
        if (c >= NP) c = c - NP;
        idx = IW'(c);
        if (!win_vld[o] && cand[o][idx]) begin
          win_vld[o] = 1'b1;
          win_idx[o] = idx;
        end
      end
    end
  end

  // Transfers happen only in LOCKED, gated by the owner's FIFO and downstream.
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      xfer[o]       = (state_q[o] == LOCKED) && req_valid[owner_q[o]] && out_ready[o];
      owner_tail[o] = flit_tail[owner_q[o]];
    end
  end

  // rd_en is the OR of each input's grant across outputs.
  always_comb begin
    rd_en = '0;
    for (int o = 0; o < NP; o++) begin
      if (xfer[o]) rd_en[owner_q[o]] = 1'b1;
    end
  end

  always_comb begin
    out_sel = '0;
    for (int o = 0; o < NP; o++) begin
      out_sel[IW*o +: IW] = owner_q[o];
    end
  end

  assign out_en   = xfer;
  assign out_busy = busy_q;

  // Per-output FSM. Pointer resets to NP-1 so input 0 has first priority.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // output's FSM sees the same pre-edge values regardless of loop order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NP; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= IW'(NP - 1);
        busy_q[o]  <= 1'b0;
      end
    end else begin
      for (int o = 0; o < NP; o++) begin
        case (state_q[o])
          IDLE: begin
            if (win_vld[o]) begin
              state_q[o] <= LOCKED;
              owner_q[o] <= win_idx[o];
              busy_q[o]  <= 1'b1;
            end
          end
          LOCKED: begin
            if (xfer[o] && owner_tail[o]) begin
              state_q[o] <= IDLE;
              ptr_q[o]   <= owner_q[o];
              busy_q[o]  <= 1'b0;
            end
          end
          default: begin
            state_q[o] <= IDLE;
            busy_q[o]  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_output_port_allocator.sv
// -----------------------------------------------------------------------------
// tb_output_port_allocator
//
// Table-driven directed vectors for reset, single-flit, round-robin
// contention, backpressure and parallel/illegal requests; a hand-written
// sequence for an asynchronous reset in the middle of a packet; then
// randomized traffic compared cycle by cycle against a behavioural model.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_output_port_allocator;

  logic        clk;
  logic        rst;
  logic [6:0]  req_valid;
  logic [20:0] req_port;
  logic [6:0]  flit_tail;
  logic [6:0]  out_ready;
  logic [6:0]  rd_en;
  logic [6:0]  out_en;
  logic [20:0] out_sel;
  logic [6:0]  out_busy;

  int n_checks = 0;
  int n_fail   = 0;

  output_port_allocator #(.NP(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_port  (req_port),
    .flit_tail (flit_tail),
    .out_ready (out_ready),
    .rd_en     (rd_en),
    .out_en    (out_en),
    .out_sel   (out_sel),
    .out_busy  (out_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [6:0]  rv;
    logic [20:0] rp;
    logic [6:0]  ft;
    logic [6:0]  ordy;
    logic [6:0]  e_rd;
    logic [6:0]  e_en;
    logic [6:0]  e_busy;
    logic [20:0] e_sel;
  } vec_t;

  vec_t vecs[$];

  // ---------------- behavioural model ----------------
  // Each output is either free or held by a packet from some input; a free
  // output remembers the input it last served for round-robin purposes.
  bit   m_lock [7];
  int   m_own  [7];
  int   m_last [7];

  task automatic model_reset();
    for (int o = 0; o < 7; o++) begin
      m_lock[o] = 0;
      m_own[o]  = 0;
      m_last[o] = 6;
    end
  endtask

  function automatic int dest(input int i);
    return int'(req_port[3*i +: 3]);
  endfunction

  task automatic model_expect(output logic [6:0] e_rd, output logic [6:0] e_en,
                              output logic [6:0] e_busy, output logic [20:0] e_sel);
    e_rd = '0; e_en = '0; e_busy = '0; e_sel = '0;
    for (int o = 0; o < 7; o++) begin
      e_sel[3*o +: 3] = 3'(m_own[o]);
      e_busy[o]       = m_lock[o];
      if (m_lock[o] && req_valid[m_own[o]] && out_ready[o]) begin
        e_en[o]          = 1'b1;
        e_rd[m_own[o]]   = 1'b1;
      end
    end
  endtask

  task automatic model_next();
    bit busy_in [7];
    bit nl [7];
    int no [7];
    int nlast [7];
    for (int i = 0; i < 7; i++) busy_in[i] = 0;
    for (int o = 0; o < 7; o++) if (m_lock[o]) busy_in[m_own[o]] = 1;
    for (int o = 0; o < 7; o++) begin
      nl[o] = m_lock[o]; no[o] = m_own[o]; nlast[o] = m_last[o];
      if (!m_lock[o]) begin
        for (int k = 1; k <= 7; k++) begin
          int i;
          i = (m_last[o] + k) % 7;
          if (!nl[o] && req_valid[i] && dest(i) == o && i != o && !busy_in[i]) begin
            nl[o] = 1; no[o] = i;
          end
        end
      end else if (req_valid[m_own[o]] && out_ready[o] && flit_tail[m_own[o]]) begin
        nl[o] = 0; nlast[o] = m_own[o];
      end
    end
    for (int o = 0; o < 7; o++) begin
      m_lock[o] = nl[o]; m_own[o] = no[o]; m_last[o] = nlast[o];
    end
  endtask

  task automatic model_step();
    if (!rst) model_reset();
    else      model_next();
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] set_rp(input logic [20:0] base, input int i, input int o);
    logic [20:0] r;
    r = base;
    r[3*i +: 3] = 3'(o);
    return r;
  endfunction

  task automatic add(input string name, input logic r, input logic [6:0] rv,
                     input logic [20:0] rp, input logic [6:0] ft, input logic [6:0] ordy,
                     input logic [6:0] e_rd, input logic [6:0] e_en,
                     input logic [6:0] e_busy, input logic [20:0] e_sel);
    vec_t v;
    v.name = name; v.rst = r; v.rv = rv; v.rp = rp; v.ft = ft; v.ordy = ordy;
    v.e_rd = e_rd; v.e_en = e_en; v.e_busy = e_busy; v.e_sel = e_sel;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [6:0] rv, input logic [20:0] rp,
                       input logic [6:0] ft, input logic [6:0] ordy);
    @(negedge clk);
    rst = r; req_valid = rv; req_port = rp; flit_tail = ft; out_ready = ordy;
    #1;
  endtask

  task automatic check_all(input string name, input logic [6:0] e_rd, input logic [6:0] e_en,
                           input logic [6:0] e_busy, input logic [20:0] e_sel);
    check({name, ".rd_en"},    21'(rd_en),    21'(e_rd));
    check({name, ".out_en"},   21'(out_en),   21'(e_en));
    check({name, ".out_busy"}, 21'(out_busy), 21'(e_busy));
    check({name, ".out_sel"},  out_sel,       e_sel);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [20:0] nr;
    logic [20:0] p;
    logic [6:0]  e_rd, e_en, e_busy;
    logic [20:0] e_sel;

    rst = 1'b0; req_valid = '0; req_port = '1; flit_tail = '0; out_ready = '1;
    model_reset();
    nr = '1;

    // Reset held with arbitrary activity, then idle after release.
    add("rst_hold", 0, 7'h7f, 21'h0, 7'h7f, 7'h7f, 0, 0, 0, 0);
    add("idle0",    1, 7'h00, nr,    7'h00, 7'h7f, 0, 0, 0, 0);
    add("idle1",    1, 7'h00, nr,    7'h00, 7'h7f, 0, 0, 0, 0);

    // Single-flit packet: input 0 -> output 4.
    p = set_rp(nr, 0, 4);
    add("sf_t0", 1, 7'h01, p, 7'h01, 7'h7f, 7'h00, 7'h00, 7'h00, 0);
    add("sf_t1", 1, 7'h01, p, 7'h01, 7'h7f, 7'h01, 7'h10, 7'h10, 0);
    add("sf_t2", 1, 7'h00, p, 7'h01, 7'h7f, 7'h00, 7'h00, 7'h00, 0);
    add("rst_a", 0, 7'h00, nr, 7'h00, 7'h7f, 0, 0, 0, 0);

    // Contention: inputs 1,3,5 -> output 2, 3-flit packets. Order 1,3,5,1.
    p = set_rp(set_rp(set_rp(nr, 1, 2), 3, 2), 5, 2);
    add("rr_c0",  1, 7'h2a, p, 7'h00, 7'h7f, 7'h00, 7'h00, 7'h00, 21'h000);
    add("rr_c1",  1, 7'h2a, p, 7'h00, 7'h7f, 7'h02, 7'h04, 7'h04, 21'h040);
    add("rr_c2",  1, 7'h2a, p, 7'h00, 7'h7f, 7'h02, 7'h04, 7'h04, 21'h040);
    add("rr_c3",  1, 7'h2a, p, 7'h02, 7'h7f, 7'h02, 7'h04, 7'h04, 21'h040);
    add("rr_c4",  1, 7'h2a, p, 7'h00, 7'h7f, 7'h00, 7'h00, 7'h00, 21'h040);
    add("rr_c5",  1, 7'h2a, p, 7'h00, 7'h7f, 7'h08, 7'h04, 7'h04, 21'h0c0);
    add("rr_c6",  1, 7'h2a, p, 7'h00, 7'h7f, 7'h08, 7'h04, 7'h04, 21'h0c0);
    add("rr_c7",  1, 7'h2a, p, 7'h08, 7'h7f, 7'h08, 7'h04, 7'h04, 21'h0c0);
    add("rr_c8",  1, 7'h2a, p, 7'h00, 7'h7f, 7'h00, 7'h00, 7'h00, 21'h0c0);
    add("rr_c9",  1, 7'h2a, p, 7'h00, 7'h7f, 7'h20, 7'h04, 7'h04, 21'h140);
    add("rr_c10", 1, 7'h2a, p, 7'h00, 7'h7f, 7'h20, 7'h04, 7'h04, 21'h140);
    add("rr_c11", 1, 7'h2a, p, 7'h20, 7'h7f, 7'h20, 7'h04, 7'h04, 21'h140);
    add("rr_c12", 1, 7'h2a, p, 7'h00, 7'h7f, 7'h00, 7'h00, 7'h00, 21'h140);
    add("rr_c13", 1, 7'h2a, p, 7'h00, 7'h7f, 7'h02, 7'h04, 7'h04, 21'h040);
    add("rst_b", 0, 7'h00, nr, 7'h00, 7'h7f, 0, 0, 0, 0);

    // Backpressure: input 2 -> output 0, 4 flits, 2-cycle stall after flit 2.
    p = set_rp(nr, 2, 0);
    add("bp_c0", 1, 7'h04, p, 7'h00, 7'h7f, 7'h00, 7'h00, 7'h00, 21'h0);
    add("bp_f1", 1, 7'h04, p, 7'h00, 7'h7f, 7'h04, 7'h01, 7'h01, 21'h2);
    add("bp_f2", 1, 7'h04, p, 7'h00, 7'h7f, 7'h04, 7'h01, 7'h01, 21'h2);
    add("bp_s1", 1, 7'h04, p, 7'h00, 7'h7e, 7'h00, 7'h00, 7'h01, 21'h2);
    add("bp_s2", 1, 7'h04, p, 7'h00, 7'h7e, 7'h00, 7'h00, 7'h01, 21'h2);
    add("bp_f3", 1, 7'h04, p, 7'h00, 7'h7f, 7'h04, 7'h01, 7'h01, 21'h2);
    add("bp_f4", 1, 7'h04, p, 7'h04, 7'h7f, 7'h04, 7'h01, 7'h01, 21'h2);
    add("bp_end",1, 7'h00, p, 7'h00, 7'h7f, 7'h00, 7'h00, 7'h00, 21'h2);
    add("rst_c", 0, 7'h00, nr, 7'h00, 7'h7f, 0, 0, 0, 0);

    // Parallel and illegal: 0->1, 1->0, 6->6 (U-turn), 5 has no route.
    p = set_rp(set_rp(set_rp(nr, 0, 1), 1, 0), 6, 6);
    add("par_c0", 1, 7'h63, p, 7'h63, 7'h7f, 7'h00, 7'h00, 7'h00, 21'h0);
    add("par_c1", 1, 7'h63, p, 7'h63, 7'h7f, 7'h03, 7'h03, 7'h03, 21'h1);
    add("par_c2", 1, 7'h63, p, 7'h63, 7'h7f, 7'h00, 7'h00, 7'h00, 21'h1);
    add("par_c3", 1, 7'h63, p, 7'h63, 7'h7f, 7'h03, 7'h03, 7'h03, 21'h1);
    add("par_c4", 1, 7'h00, p, 7'h00, 7'h7f, 7'h00, 7'h00, 7'h00, 21'h1);
    add("rst_d", 0, 7'h00, nr, 7'h00, 7'h7f, 0, 0, 0, 0);

    // Reset held with random inputs.
    for (int k = 0; k < 4; k++) begin
      drive(0, 7'($urandom), 21'($urandom), 7'($urandom), 7'($urandom));
      check_all("rst_rand", 0, 0, 0, 0);
      model_step();
    end

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].rv, vecs[k].rp, vecs[k].ft, vecs[k].ordy);
      check_all(vecs[k].name, vecs[k].e_rd, vecs[k].e_en, vecs[k].e_busy, vecs[k].e_sel);
      model_step();
    end

    // Reset in the middle of a 5-flit packet from input 3 to output 5.
    p = set_rp(nr, 3, 5);
    drive(1, 7'h08, p, 7'h00, 7'h7f);
    check_all("mr_arb", 7'h00, 7'h00, 7'h00, 21'h0);
    model_step();
    drive(1, 7'h08, p, 7'h00, 7'h7f);
    check_all("mr_f1", 7'h08, 7'h20, 7'h20, 21'h18000);
    model_step();
    drive(1, 7'h08, p, 7'h00, 7'h7f);
    check_all("mr_f2", 7'h08, 7'h20, 7'h20, 21'h18000);
    model_step();
    #1 rst = 1'b0;
    #1;
    check_all("mr_rst", 7'h00, 7'h00, 7'h00, 21'h0);
    model_reset();
    drive(1, 7'h08, p, 7'h00, 7'h7f);
    check_all("mr_rearb", 7'h00, 7'h00, 7'h00, 21'h0);
    model_step();
    drive(1, 7'h08, p, 7'h00, 7'h7f);
    check_all("mr_relock", 7'h08, 7'h20, 7'h20, 21'h18000);
    model_step();
    drive(0, 7'h00, nr, 7'h00, 7'h7f);
    check_all("mr_end", 0, 0, 0, 0);
    model_step();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        r;
      logic [6:0]  rv, ft, ordy;
      logic [20:0] rp;
      r = ($urandom_range(0, 199) != 0);
      rv = 7'($urandom);
      rp = '0;
      ft = '0;
      ordy = '0;
      for (int i = 0; i < 7; i++) begin
        rp[3*i +: 3] = 3'($urandom_range(0, 7));
        ft[i]        = ($urandom_range(0, 2) == 0);
        ordy[i]      = ($urandom_range(0, 4) != 0);
      end
      drive(r, rv, rp, ft, ordy);
      if (!rst) model_reset();
      model_expect(e_rd, e_en, e_busy, e_sel);
      check_all("rand", e_rd, e_en, e_busy, e_sel);
      if (rst) model_next();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_port_allocator.md
# output_port_allocator

Switch allocator for the seven-port (E, W, N, S, PE, UP, DOWN) wormhole router. It takes per-input route requests from the routing-computation stage and performs a round-robin arbitration per output port. The winning input holds the output until its tail flit has crossed. It drives the input-FIFO read enables and the per-output crossbar mux select/enable, and it honours downstream flow control.

## Interface
Port index is used everywhere: 0=E, 1=W, 2=N, 3=S, 4=PE, 5=UP, 6=DOWN.

Parameters:
- NP, 7, number of router ports. Fixed at 7; index width is 3.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  7  bit i: input FIFO i is non-empty and its route is computed.
- req_port  in  21  bits [3i+2:3i]: destination output index for input i.
  - Values 0..6 name an output.
  - 7 means no route.
- flit_tail  in  7  bit i: the flit at the head of input FIFO i is a tail flit (a single-flit packet has tail=1).
- out_ready  in  7  bit o: the downstream router or PE can accept a flit on output o this cycle.
- rd_en  out  7  bit i: pop input FIFO i this cycle.
- out_en  out  7  bit o: crossbar output o carries a valid flit this cycle.
- out_sel  out  21  bits [3o+2:3o]: input index currently owning output o.
- out_busy  out  7  bit o: output o is locked to a packet.

## Operation
- Each output o has its own two-state FSM: IDLE and LOCKED.
  - Registered state: owner[o] (3 bits) and round-robin pointer ptr[o] (3 bits).
- Request qualification. Input i is a candidate for output o when all of the following hold:
  - req_valid[i]=1;
  - req_port[i]==o;
  - i!=o (U-turn requests are ignored; they are never granted);
  - input i is not already owner of any LOCKED output.
  - req_port=7 is never a candidate.
- IDLE:
  - Search candidates starting at index ptr[o]+1, wrapping 6->0; the first candidate found wins.
  - On a win: owner[o]<=winner, state<=LOCKED, out_busy[o]<=1.
  - No candidate: stay IDLE.
  - Arbitration in IDLE does not move a flit; transfers happen only in LOCKED.
- LOCKED:
  - Transfer condition: req_valid[owner] & out_ready[o].
  - When it holds, out_en[o]=1 and rd_en[owner]=1 in the same cycle (combinational from registered state and inputs).
  - Transfer with flit_tail[owner]=1: state<=IDLE, ptr[o]<=owner, out_busy[o]<=0.
  - No transfer (FIFO momentarily empty or downstream stalled): hold the lock and assert nothing. The lock never times out.
- rd_en[i] is the OR of that input's grant over all outputs. Because of the qualification rule, at most one output can own input i.
- Independent outputs operate in parallel. Up to 7 transfers per cycle.
- out_sel[o] holds owner[o] in both states; it does not change while IDLE.

## Timing
- Reset (rst=0, asynchronous) clears all registers:
  - every FSM to IDLE;
  - owner=0 and ptr=6 for every output, so input 0 has first priority;
  - out_busy=0, out_sel=0.
  - rd_en and out_en are 0 immediately, because they are gated by state=LOCKED.
- Reset asserted mid-packet aborts the lock. The remaining flits of that packet are not tracked.
- Grant latency: a request first valid in cycle t gives LOCKED in cycle t+1. The head flit transfers in t+1 if out_ready=1.
- Throughput inside a packet: 1 flit/cycle per output.
- Release-to-regrant: tail transfers in cycle t; IDLE in t+1 with arbitration; next packet's head moves in t+2. This is one bubble per packet boundary on that output.
- A single-flit packet (tail on the head flit) locks for exactly one transfer cycle.
- A request that drops (req_valid=0) while its output is still IDLE is simply not considered. No state is retained for it.
- out_ready is sampled only in LOCKED. Arbitration never waits on out_ready.

## Test plan
- Reset: hold rst=0 with random inputs. Required: rd_en=0, out_en=0, out_busy=0, out_sel=0. Release rst and keep all req_valid=0: outputs stay 0.
- Single-flit packet:
  - Stimulus: input 0 requests output 4 with flit_tail[0]=1 and all out_ready=1, starting at cycle t.
  - Cycle t+1: rd_en=7'b0000001, out_en[4]=1, out_sel[4]=0, out_busy[4]=1.
  - Cycle t+2: out_busy[4]=0, rd_en=0.
- Contention and round-robin fairness:
  - Stimulus: after reset, inputs 1, 3 and 5 all request output 2 continuously with 3-flit packets (tail on the 3rd).
  - Required grant order: 1, 3, 5, 1.
  - Each owner gets 3 consecutive rd_en pulses, with one idle cycle between packets.
- Backpressure:
  - Stimulus: input 2 sends a 4-flit packet to output 0; drop out_ready[0] for 2 cycles after flit 2.
  - Required: rd_en[2]=0 and out_en[0]=0 during the stall, out_busy[0] stays 1, flits 3 and 4 transfer on the next 2 ready cycles.
- Parallel and illegal requests, all in the same cycle:
  - Stimulus: input 0 requests output 1, input 1 requests output 0, input 6 requests output 6 (U-turn), input 5 has req_port=7.
  - Required: outputs 0 and 1 lock in the same cycle, with rd_en[0] and rd_en[1] both 1.
  - Required: input 6 and input 5 are never granted.
- Reset mid-packet:
  - Stimulus: drop rst to 0 during flit 2 of a 5-flit packet from input 3 to output 5.
  - Required: out_busy[5] and rd_en fall to 0 immediately.
  - After rst returns to 1, input 3 is re-arbitrated from IDLE as a new request.
